// File: rtl/sync_down_counter_pkg.sv
// Shared constants for the button-driven counter family.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package counter_pkg;

    // Default counter width for the board build.
    localparam int DEFAULT_WIDTH = 3;

    // 10 ms of stable input at 100 MHz before a button change is accepted.
    localparam int DEBOUNCE_CYCLES_100MHZ = 1000000;

    // Short debounce window so simulations finish in a few hundred cycles.
    localparam int SIM_DEBOUNCE_CYCLES = 4;

    // Width of a counter that must hold values 0 .. n-1 (never less than 1 bit).
    function automatic int cnt_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sync_down_counter_if.sv
// Control and status bundle between the board/driver side and the down counter.
// Latency: n/a (wiring only).
// Backpressure: none; all signals are plain levels or one-cycle pulses.
interface sync_down_counter_if
    import counter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             step_btn;
    logic             load;
    logic [WIDTH-1:0] load_value;
    logic             wrap_en;
    logic [WIDTH-1:0] count;
    logic             zero;
    logic             borrow_pulse;

    // Board / driver side: owns the button and the control strobes.
    modport master (
        output step_btn, load, load_value, wrap_en,
        input  count, zero, borrow_pulse
    );

    // Counter side: consumes controls, produces the count and status.
    modport slave (
        input  step_btn, load, load_value, wrap_en,
        output count, zero, borrow_pulse
    );
endinterface

// File: rtl/sync_down_counter_btn_debounce.sv
// Synchronise, debounce and edge-detect a raw push-button into a one-cycle rise pulse.
// Latency: btn_rise asserts SYNC_STAGES+DEBOUNCE_CYCLES edges after the first sampled 1.
// Backpressure: none; a bounce shorter than the debounce window is simply dropped.
module btn_debounce
    import counter_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_100MHZ
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_rise
);
    localparam int            CW      = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt_q;
    logic                   level_q;
    logic                   level_d_q;
    logic                   rise_q;
    logic                   btn_sync;

    assign btn_sync  = sync_q[SYNC_STAGES-1];
    assign btn_level = level_q;
    assign btn_rise  = rise_q;

    // Shift the raw button in, accept a new level only after a full stable window, then register the rising edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q    <= '0;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            level_d_q <= 1'b0;
            rise_q    <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], btn_raw};
            if (btn_sync != level_q) begin
                if (cnt_q == CNT_MAX) begin
                    level_q <= btn_sync;
                    cnt_q   <= '0;
                end else begin
                    cnt_q <= cnt_q + CW'(1);
                end
            end else begin
                cnt_q <= '0;
            end
            level_d_q <= level_q;
            rise_q    <= level_q & ~level_d_q;
        end
    end
endmodule

// File: rtl/sync_down_counter.sv
// Button-stepped down counter with parallel load, wrap/saturate at zero and a cascadable borrow pulse.
// Latency: count moves SYNC_STAGES+DEBOUNCE_CYCLES+1 edges after the first sampled button press.
// Backpressure: none; a step coinciding with load is discarded, not deferred.
module sync_down_counter
    import counter_pkg::*;
#(
    parameter int WIDTH           = DEFAULT_WIDTH,
    parameter int RESET_VALUE     = 2**WIDTH - 1,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_100MHZ,
    parameter int SYNC_STAGES     = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    sync_down_counter_if.slave   bus
);
    localparam logic [WIDTH-1:0] RESET_COUNT = WIDTH'(RESET_VALUE);

    logic [WIDTH-1:0] count_q;
    logic             borrow_q;
    logic             step;
    logic             btn_level_unused;

    btn_debounce #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_btn (
        .clk       (clk),
        .reset     (reset),
        .btn_raw   (bus.step_btn),
        .btn_level (btn_level_unused),
        .btn_rise  (step)
    );

    assign bus.count        = count_q;
    assign bus.zero         = (count_q == '0);
    assign bus.borrow_pulse = borrow_q;

    // Load beats step; a step at zero either wraps with a borrow pulse or saturates.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q  <= RESET_COUNT;
            borrow_q <= 1'b0;
        end else begin
            borrow_q <= 1'b0;
            if (bus.load) begin
                count_q <= bus.load_value;
            end else if (step) begin
                if (count_q != '0) begin
                    count_q <= count_q - WIDTH'(1);
                end else if (bus.wrap_en) begin
                    count_q  <= '1;
                    borrow_q <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_sync_down_counter.sv
// Directed bench for sync_down_counter with a cycle-level reference model and literal anchors.
// Latency: n/a.
// Backpressure: n/a.
module tb_sync_down_counter;
    import counter_pkg::*;

    localparam int W = 3;
    localparam int D = SIM_DEBOUNCE_CYCLES;

    logic clk = 1'b0;
    logic reset = 1'b1;

    int n_checks = 0;
    int n_errors = 0;
    int n_borrow = 0;

    sync_down_counter_if #(.WIDTH(W)) bus ();

    sync_down_counter #(
        .WIDTH           (W),
        .RESET_VALUE     (7),
        .DEBOUNCE_CYCLES (D),
        .SYNC_STAGES     (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the button seen by the debouncer is the raw sample from two edges
    // earlier; a level change is accepted after D consecutive mismatched edges; the
    // resulting step acts on the count two edges after the level is accepted.
    int         m_edge = 0;
    int         m_step_edge = -1;
    logic [1:0] m_dly = 2'b00;
    logic       m_level = 1'b0;
    int         m_run = 0;
    int         m_count = 7;
    int         m_borrow = 0;
    bit         m_valid = 1'b0;

    always @(posedge clk) begin
        logic seen;
        bit   step_now;
        if (reset) begin
            m_dly       = 2'b00;
            m_level     = 1'b0;
            m_run       = 0;
            m_step_edge = -1;
            m_count     = 7;
            m_borrow    = 0;
            m_valid     = 1'b1;
        end else begin
            seen     = m_dly[1];
            step_now = (m_step_edge == m_edge);
            m_dly    = {m_dly[0], bus.step_btn};
            if (seen != m_level) begin
                if (m_run == D - 1) begin
                    m_level = seen;
                    m_run   = 0;
                    if (seen) m_step_edge = m_edge + 2;
                end else begin
                    m_run++;
                end
            end else begin
                m_run = 0;
            end
            m_borrow = 0;
            if (bus.load) begin
                m_count = int'(bus.load_value);
            end else if (step_now) begin
                if (m_count > 0) begin
                    m_count = m_count - 1;
                end else if (bus.wrap_en) begin
                    m_count  = (1 << W) - 1;
                    m_borrow = 1;
                end
            end
        end
        m_edge++;
    end

    // Every cycle, compare all outputs against the model and tally borrow pulses.
    always @(negedge clk) begin
        if (m_valid) begin
            check("model_count", int'(bus.count), m_count);
            check("model_zero", int'(bus.zero), (m_count == 0) ? 1 : 0);
            check("model_borrow", int'(bus.borrow_pulse), m_borrow);
        end
        if (bus.borrow_pulse) n_borrow++;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press();
        bus.step_btn = 1'b1;
        cyc(10);
        bus.step_btn = 1'b0;
        cyc(10);
    endtask

    task automatic load_val(input int v);
        bus.load       = 1'b1;
        bus.load_value = W'(v);
        cyc(1);
        bus.load       = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc(2);
        reset = 1'b0;
    endtask

    initial begin
        int b0;
        bus.step_btn   = 1'b0;
        bus.load       = 1'b0;
        bus.load_value = '0;
        bus.wrap_en    = 1'b0;
        cyc(3);
        reset = 1'b0;

        // Reset state
        check("reset_count", int'(bus.count), 7);
        check("reset_zero", int'(bus.zero), 0);
        check("reset_borrow", int'(bus.borrow_pulse), 0);

        // 1: clean press, count moves exactly 7 edges after the first sampled 1
        b0 = n_borrow;
        bus.step_btn = 1'b1;
        cyc(7);
        check("t1_before_step", int'(bus.count), 7);
        cyc(1);
        check("t1_after_step", int'(bus.count), 6);
        cyc(2);
        bus.step_btn = 1'b0;
        cyc(10);
        check("t1_single_dec", int'(bus.count), 6);
        check("t1_no_borrow", n_borrow - b0, 0);

        // 2: short bounce is rejected, then a clean press counts once
        bus.step_btn = 1'b1; cyc(1);
        bus.step_btn = 1'b0; cyc(1);
        bus.step_btn = 1'b1; cyc(1);
        bus.step_btn = 1'b0; cyc(12);
        check("t2_bounce_ignored", int'(bus.count), 6);
        press();
        check("t2_clean_press", int'(bus.count), 5);

        // 3: wrap at zero with borrow, then saturate with no borrow
        bus.wrap_en = 1'b1;
        load_val(0);
        check("t3_loaded_zero", int'(bus.zero), 1);
        b0 = n_borrow;
        press();
        check("t3_wrap_count", int'(bus.count), 7);
        check("t3_one_borrow", n_borrow - b0, 1);
        bus.wrap_en = 1'b0;
        load_val(0);
        b0 = n_borrow;
        press();
        check("t3_sat_count", int'(bus.count), 0);
        check("t3_sat_no_borrow", n_borrow - b0, 0);

        // 4: load coinciding with the step wins and the step is lost
        load_val(7);
        bus.step_btn = 1'b1;
        cyc(7);
        load_val(5);
        check("t4_load_wins", int'(bus.count), 5);
        cyc(2);
        bus.step_btn = 1'b0;
        cyc(10);
        check("t4_no_late_step", int'(bus.count), 5);
        press();
        check("t4_next_press", int'(bus.count), 4);

        // 5: reset mid-debounce with the button held restarts the press
        bus.step_btn = 1'b1;
        cyc(4);
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        check("t5_reset_count", int'(bus.count), 7);
        cyc(7);
        check("t5_before_step", int'(bus.count), 7);
        cyc(1);
        check("t5_after_step", int'(bus.count), 6);
        cyc(2);
        bus.step_btn = 1'b0;
        cyc(10);
        check("t5_single_step", int'(bus.count), 6);

        // 6: seven presses walk 7 down to 0, an eighth saturates
        do_reset();
        bus.wrap_en = 1'b0;
        b0 = n_borrow;
        for (int i = 1; i <= 7; i++) begin
            press();
            check("t6_walk", int'(bus.count), 7 - i);
        end
        check("t6_zero", int'(bus.zero), 1);
        press();
        check("t6_saturate", int'(bus.count), 0);
        check("t6_zero_held", int'(bus.zero), 1);
        check("t6_no_borrow", n_borrow - b0, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/sync_down_counter.md
Name: sync_down_counter

Overview:
- Fully synchronous down counter, the count-down counterpart of the team's button-driven ripple up counter.
- Single clock domain. A raw push-button is synchronised and debounced, then converted to a one-cycle step pulse; each pulse decrements the count.
- Supports parallel load, wrap or saturate at zero, and a borrow pulse that can cascade into a further stage.
- Drives LEDs directly on the board top level.

Parameters:
- WIDTH, 3, counter width in bits.
- RESET_VALUE, 2**WIDTH-1, count value loaded by reset.
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles needed to accept a button change (10 ms at 100 MHz).
- SYNC_STAGES, 2, flip-flop depth of the input synchroniser (minimum 2).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high; clears all state.
- step_btn  input  1  raw asynchronous push-button, active-high, may bounce.
- load  input  1  synchronous parallel-load strobe.
- load_value  input  WIDTH  value loaded when load=1.
- wrap_en  input  1  1 = wrap from 0 to all-ones; 0 = saturate at 0.
- count  output  WIDTH  current count, registered.
- zero  output  1  combinational, count==0.
- borrow_pulse  output  1  registered one-cycle pulse on wrap from 0 to all-ones.

Behaviour:
- Reset values:
  - count=RESET_VALUE, borrow_pulse=0, zero=(RESET_VALUE==0).
  - Synchroniser flops=0, debounce counter=0, debounced level=0, edge-detect history=0.
- Synchroniser: step_btn passes through SYNC_STAGES flops to give btn_sync.
- Debounce:
  - When btn_sync != debounced level, the counter increments each cycle.
  - When they are equal, the counter clears to 0.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still mismatched, the debounced level takes btn_sync on that edge and the counter clears.
  - A bounce shorter than DEBOUNCE_CYCLES produces no level change.
- Step generation: step=1 for exactly one cycle, on the cycle after the debounced level rises 0->1. The falling edge and a held button produce nothing further.
- Latency: for a clean rising edge on step_btn, count changes on the clock edge SYNC_STAGES+DEBOUNCE_CYCLES+1 edges after the first edge that samples step_btn=1.
- Count update priority, per cycle:
  1. reset
  2. load: count<=load_value; step is ignored; borrow_pulse=0
  3. step with count>0: count<=count-1
  4. step with count==0 and wrap_en=1: count<=all-ones, borrow_pulse=1 for this one cycle
  5. step with count==0 and wrap_en=0: count holds at 0; borrow_pulse=0
  6. otherwise: hold
- Simultaneous load and step: the load wins and the step is discarded, not deferred.
- borrow_pulse is never asserted for two consecutive cycles, because step pulses are at least DEBOUNCE_CYCLES apart.
- Reset mid-debounce:
  - All in-progress debounce state is discarded.
  - If the button is still held at reset release, it is treated as a new press from a level of 0. One step is produced after the full latency.
- Arithmetic is unsigned, modulo 2**WIDTH only in the wrap case. No X propagation: every register has a reset value.

Decomposition:
- Shared package counter_pkg holds:
  - the default debounce constant for 100 MHz;
  - a simulation-override constant SIM_DEBOUNCE_CYCLES=4;
  - the WIDTH default.
- One sub-module, btn_debounce:
  - Contains the synchroniser, debounce counter and rising-edge pulse.
  - Parameters: SYNC_STAGES, DEBOUNCE_CYCLES.
  - Ports: clk, reset, btn_raw, btn_level, btn_rise.
  - Reused by other button-driven blocks.
- The top level holds only count, load, wrap and borrow logic.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4, SYNC_STAGES=2, WIDTH=3.
1. Reset, then a clean press held for 10 cycles -> count goes 7->6 exactly 7 edges after the first sampled 1. There is exactly one decrement, and borrow_pulse=0.
2. Toggle step_btn 1,0,1,0 on alternate cycles, then hold 0 -> no step and count unchanged. Then a clean press gives exactly one decrement.
3. wrap_en=1, load 0, then one press -> count=7, and borrow_pulse=1 for one cycle on the same edge. With wrap_en=0 and the same stimulus, count stays 0 and borrow_pulse stays 0.
4. Time the press so the step pulse coincides with load=1 and load_value=5 -> count=5 with no decrement. The next press gives 4.
5. Assert reset for one cycle mid-debounce (counter at 2) while the button is held -> count=7. One step follows, 7 edges after reset deasserts.
6. Seven presses from reset with wrap_en=0 -> count steps 7..0 and zero=1. An eighth press keeps count=0.
